// File: rtl/seq_neuron_if.sv
// Handshake bundle for seq_neuron: input vector channel and result channel.
interface seq_neuron_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH*N-1:0]       in_flat;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [WIDTH-1:0]  out;
  logic                     out_sat;

  modport master (
    output in_valid, in_flat, out_ready,
    input  in_ready, out_valid, out, out_sat
  );

  modport slave (
    input  in_valid, in_flat, out_ready,
    output in_ready, out_valid, out, out_sat
  );
endinterface

// File: rtl/seq_neuron.sv
// Sequential fixed-point neuron: one multiply-accumulate per cycle over N channels,
// then floor-shift, saturate and optional ReLU into a held result.
module seq_neuron #(
  parameter int                          WIDTH        = 16,
  parameter int                          N            = 4,
  parameter int                          FRAC_BITS    = 8,
  parameter logic signed [WIDTH*N-1:0]   WEIGHTS_FLAT = '0,
  parameter logic signed [WIDTH-1:0]     BIAS         = '0,
  parameter bit                          RELU_EN      = 1'b0
) (
  input logic        clk,
  input logic        rst,
  seq_neuron_if.slave nif
);
  localparam int ACC_W = 2 * WIDTH + $clog2(N) + 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [ACC_W-1:0] BIAS_ACC = ACC_W'(BIAS) <<< FRAC_BITS;
  localparam logic signed [ACC_W-1:0] MAX_C    = ACC_W'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] MIN_C    = -MAX_C - 1;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [WIDTH*N-1:0]        in_q, in_d;
  logic signed [WIDTH-1:0]   out_q, out_d;
  logic                      sat_q, sat_d;

  logic signed [WIDTH-1:0]   x_a [N];
  logic signed [WIDTH-1:0]   w_a [N];
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [WIDTH-1:0]   res;
  logic                      res_sat;

  // Element 0 sits in the most significant slice of both flat vectors.
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign x_a[i] = in_q[(N-i)*WIDTH-1 -: WIDTH];
    assign w_a[i] = WEIGHTS_FLAT[(N-i)*WIDTH-1 -: WIDTH];
  end

  assign prod    = x_a[idx_q] * w_a[idx_q];
  assign sum     = acc_q + ACC_W'(prod);
  assign shifted = sum >>> FRAC_BITS;

  always_comb begin
    res     = shifted[WIDTH-1:0];
    res_sat = 1'b0;
    if (shifted > MAX_C) begin
      res     = MAX_C[WIDTH-1:0];
      res_sat = 1'b1;
    end else if (shifted < MIN_C) begin
      res     = MIN_C[WIDTH-1:0];
      res_sat = 1'b1;
    end
    if (RELU_EN && res[WIDTH-1]) res = '0;
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    idx_d         = idx_q;
    in_d          = in_q;
    out_d         = out_q;
    sat_d         = sat_q;
    nif.in_ready  = (state_q == IDLE);
    nif.out_valid = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (nif.in_valid) begin
          in_d    = nif.in_flat;
          acc_d   = BIAS_ACC;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = sum;
        if (idx_q == IDX_W'(N - 1)) begin
          out_d   = res;
          sat_d   = res_sat;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (nif.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      in_q    <= '0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      in_q    <= in_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
    end
  end

  assign nif.out     = out_q;
  assign nif.out_sat = sat_q;
endmodule

// File: doc/seq_neuron.md
SEQ_NEURON -- requirements
Module: seq_neuron

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the signed data/weight/output width.
REQ-002 SHALL have parameter N, default 4, meaning the input channel count (N >= 1).
REQ-003 SHALL have parameter FRAC_BITS, default 8, meaning the fixed-point fractional bits of inputs, weights, bias and output.
REQ-004 SHALL have parameter WEIGHTS_FLAT, default 0 (WIDTH*N bits, signed), meaning the packed weights; element i = bits [(N-i)*WIDTH-1 -: WIDTH].
REQ-005 SHALL have parameter BIAS, default 0 (WIDTH bits, signed), meaning the additive bias in the same Q format.
REQ-006 SHALL have parameter RELU_EN, default 0, meaning that 1 clamps negative outputs to 0.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-009 SHALL have port in_valid, input, 1 bit, meaning in_flat holds a valid vector.
REQ-010 SHALL have port in_ready, output, 1 bit, meaning the block accepts a vector this cycle.
REQ-011 SHALL have port in_flat, input, WIDTH*N bits, meaning the packed signed inputs, with the same element ordering as WEIGHTS_FLAT.
REQ-012 SHALL have port out_valid, output, 1 bit, meaning out and out_sat hold a result.
REQ-013 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-014 SHALL have port out, output, WIDTH bits, signed, meaning the neuron result.
REQ-015 SHALL have port out_sat, output, 1 bit, meaning the result was saturated.

Function
REQ-016 SHALL implement an FSM with states IDLE, MAC and DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE.
REQ-018 SHALL, on in_valid && in_ready, latch in_flat, load the accumulator with BIAS <<< FRAC_BITS (sign-extended), clear index idx to 0, and go to MAC.
REQ-019 SHALL, in MAC, add in[idx]*w[idx] (full 2*WIDTH signed product) to the accumulator once per cycle and increment idx.
REQ-020 SHALL size the accumulator to 2*WIDTH+$clog2(N)+1 bits so that no intermediate overflow occurs.
REQ-021 SHALL, on the MAC cycle with idx == N-1, include the last product, register the final result into out and out_sat, and go to DONE.
REQ-022 SHALL, for an acceptance at edge k, present out_valid = 1 after edge k+N; the result is held until the handshake completes.
REQ-023 SHALL form the result as: full sum arithmetic-shifted right by FRAC_BITS (floor toward negative infinity); then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1], setting out_sat = 1 if clipped; then, if RELU_EN = 1, replace a negative value with 0 (out_sat unchanged).
REQ-024 SHALL assert out_valid only in DONE; in DONE, on out_ready = 1 the FSM goes to IDLE, and on out_ready = 0 out, out_sat and out_valid stay stable.
REQ-025 SHALL ignore in_valid and in_flat while in MAC or DONE; a latched vector is unaffected by in_flat changes.
REQ-026 SHALL, for N = 1, complete MAC in a single cycle.

Reset
REQ-027 SHALL, when rst = 1 at a rising edge, force IDLE, out = 0, out_sat = 0, out_valid = 0, accumulator = 0 and idx = 0; rst has priority over all other inputs.
REQ-028 SHALL, on reset mid-MAC or in DONE, discard the in-flight result; no out_valid pulse follows.

Verification
REQ-029 SHALL cover this vector: defaults with WEIGHTS_FLAT = {3072, 7808, -2560, -77} and in = {-384, 358, -77, 2586} -> sum 1613614, out = 6303, out_sat = 0, out_valid after N = 4 MAC edges.
REQ-030 SHALL cover positive saturation: in = {32767, 32767, 0, 0}, same weights -> out = 32767, out_sat = 1.
REQ-031 SHALL cover negative saturation and ReLU: in = {-32768, 0, 0, 0} -> out = -32768, out_sat = 1; in = {384, -358, 77, -2586} with RELU_EN = 1 -> out = 0 (raw -6304), out_sat = 0.
REQ-032 SHALL cover backpressure: out_ready held 0 for 5 cycles in DONE -> out, out_sat and out_valid stable, in_ready = 0 and in_valid ignored; out_ready = 1 -> IDLE next cycle and in_ready = 1.
REQ-033 SHALL cover reset mid-operation: rst asserted on the 2nd MAC cycle -> next cycle IDLE with out = 0 and out_valid = 0; a subsequent REQ-029 vector still yields 6303.
REQ-034 SHALL cover back-to-back vectors with in_valid held high -> exactly one acceptance per IDLE visit, with results in order.
